// File: rtl/embedding_writer_if.sv
// Streaming beat interface for embedding_writer: valid/ready handshake carrying
// one matrix element (or checksum) per beat with its row/column position.
interface embedding_writer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [3:0]            out_row;
    logic [3:0]            out_col;
    logic                  out_last;

    modport master (
        output out_valid, out_data, out_row, out_col, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_row, out_col, out_last,
        output out_ready
    );
endinterface

// File: rtl/embedding_writer.sv
// Captures a ROWS x COLS matrix on start and streams it row-major over a valid/ready port.
// Define EMBEDDING_WRITER_CHECKSUM_EN to append an XOR checksum beat at (15,15).
module embedding_writer #(
    parameter int ROWS       = 15,
    parameter int COLS       = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic signed [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] mat_in,
    embedding_writer_if.master                           stream,
    output logic                                         busy,
    output logic                                         done
);

    typedef enum logic [1:0] {IDLE, SEND, FINISH} state_t;

    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
    localparam logic [3:0] LAST_COL = 4'(COLS - 1);

    state_t state, state_next;
    logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] bank;
    logic [3:0] row, col;
    logic       handshake;
    logic       at_last_elem;
    logic       last_beat;

    assign handshake    = stream.out_valid & stream.out_ready;
    assign at_last_elem = (row == LAST_ROW) && (col == LAST_COL);

`ifdef EMBEDDING_WRITER_CHECKSUM_EN
    logic                  csum_beat;
    logic [DATA_WIDTH-1:0] checksum;

    always_comb begin
        checksum = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                checksum = checksum ^ bank[r][c];
            end
        end
    end

    assign last_beat = csum_beat;
`else
    assign last_beat = at_last_elem;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SEND;
            SEND:    if (handshake && last_beat) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The bank is only written on an accepted start, so start while busy cannot disturb a frame.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            bank <= mat_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
`ifdef EMBEDDING_WRITER_CHECKSUM_EN
            csum_beat <= 1'b0;
`endif
        end else if (state == IDLE) begin
            row <= '0;
            col <= '0;
`ifdef EMBEDDING_WRITER_CHECKSUM_EN
            csum_beat <= 1'b0;
`endif
        end else if (state == SEND && handshake && !last_beat) begin
`ifdef EMBEDDING_WRITER_CHECKSUM_EN
            if (at_last_elem) begin
                csum_beat <= 1'b1;
            end else
`endif
            if (col == LAST_COL) begin
                col <= '0;
                row <= row + 4'd1;
            end else begin
                col <= col + 4'd1;
            end
        end
    end

    // Outputs are decoded straight from state so they drop to zero the moment rst asserts.
    always_comb begin
        stream.out_valid = 1'b0;
        stream.out_last  = 1'b0;
        stream.out_data  = '0;
        stream.out_row   = '0;
        stream.out_col   = '0;
        if (state == SEND) begin
            stream.out_valid = 1'b1;
            stream.out_last  = last_beat;
            stream.out_data  = bank[row][col];
            stream.out_row   = row;
            stream.out_col   = col;
`ifdef EMBEDDING_WRITER_CHECKSUM_EN
            if (csum_beat) begin
                stream.out_data = checksum;
                stream.out_row  = 4'hF;
                stream.out_col  = 4'hF;
            end
`endif
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == FINISH);

endmodule
